// File: rtl/reg_bank_scan16_if.sv
// Bus bundle between the register bank / scan sequencer and whoever drives it.
// Handshake: Start is a level request sampled only while idle; Done is a one-cycle pulse after the last entry.
interface reg_bank_scan16_if #(
  parameter int WIDTH = 16
);
  logic                 WE;
  logic [3:0]           WA;
  logic [WIDTH-1:0]     WD;
  logic                 Clr;
  logic                 Start;
  logic [3:0]           Base;
  logic [3:0]           Len;
  logic [16*WIDTH-1:0]  X;
  logic [3:0]           S;
  logic                 E;
  logic                 Busy;
  logic                 Done;
  logic [1:0]           dbg_state;

  modport master (
    output WE, WA, WD, Clr, Start, Base, Len,
    input  X, S, E, Busy, Done, dbg_state
  );

  modport slave (
    input  WE, WA, WD, Clr, Start, Base, Len,
    output X, S, E, Busy, Done, dbg_state
  );
endinterface

// File: rtl/reg_bank_scan16.sv
// Sixteen-register source bank feeding a 16:1 mux, plus a scan sequencer
// that steps the mux select through a Base/Len run with a Start/Done handshake.
module reg_bank_scan16 #(
  parameter int WIDTH = 16
) (
  input  logic              Clk,
  input  logic              Reset_n,
  reg_bank_scan16_if.slave  bus
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [WIDTH-1:0] r_regs [16];
  logic [1:0]       r_state;
  logic [3:0]       r_s;
  logic [3:0]       r_rem;
  logic             r_e;
  logic             r_busy;
  logic             r_done;

  // Clear wins over a write landing in the same cycle.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if (bus.Clr) begin
      for (int i = 0; i < 16; i++) r_regs[i] <= '0;
    end else if (bus.WE) begin
      r_regs[bus.WA] <= bus.WD;
    end
  end

  for (genvar g = 0; g < 16; g++) begin : g_flat
    assign bus.X[g*WIDTH +: WIDTH] = r_regs[g];
  end

  // Start is honoured only in IDLE, so a held Start re-arms one cycle after Done.
  always_ff @(posedge Clk or negedge Reset_n) begin
    if (!Reset_n) begin
      r_state <= ST_IDLE;
      r_s     <= 4'd0;
      r_rem   <= 4'd0;
      r_e     <= 1'b0;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (bus.Start) begin
            r_s     <= bus.Base;
            r_rem   <= bus.Len;
            r_e     <= 1'b1;
            r_busy  <= 1'b1;
            r_state <= ST_SCAN;
          end
        end
        ST_SCAN: begin
          if (r_rem == 4'd0) begin
            r_e     <= 1'b0;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end else begin
            r_s   <= r_s + 4'd1;
            r_rem <= r_rem - 4'd1;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: begin
          r_e     <= 1'b0;
          r_busy  <= 1'b0;
          r_done  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign bus.S         = r_s;
  assign bus.E         = r_e;
  assign bus.Busy      = r_busy;
  assign bus.Done      = r_done;
  assign bus.dbg_state = r_state;

endmodule

// File: tb/tb_reg_bank_scan16.sv
// Directed and randomized bench for reg_bank_scan16 against an array-based
// model of the register bank and an arithmetic model of the scan sequence.
module tb_reg_bank_scan16;

  localparam int W = 16;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;

  logic [W-1:0] m_regs [16];
  logic [W-1:0] w_z;

  reg_bank_scan16_if #(.WIDTH(W)) bus ();

  reg_bank_scan16 #(.WIDTH(W)) dut (
    .Clk     (clk),
    .Reset_n (rst_n),
    .bus     (bus)
  );

  // Downstream combinational mux as seen by the consumer of X/S.
  assign w_z = bus.X[bus.S*W +: W];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [16*W-1:0] model_flat();
    logic [16*W-1:0] f;
    for (int i = 0; i < 16; i++) f[i*W +: W] = m_regs[i];
    return f;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [255:0] obs, input logic [255:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, ".E"}, bus.E, 1'b0);
    check({tag, ".Busy"}, bus.Busy, 1'b0);
    check({tag, ".Done"}, bus.Done, 1'b0);
  endtask

  task automatic write_reg(input logic [3:0] wa, input logic [W-1:0] wd);
    bus.WE = 1'b1;
    bus.WA = wa;
    bus.WD = wd;
    tick();
    bus.WE = 1'b0;
    m_regs[wa] = wd;
    check("write.X", bus.X, model_flat());
  endtask

  // Runs one scan; optional write (at entry wk) and clear (at entry ck), -1 disables.
  task automatic run_scan(input logic [3:0] base, input logic [3:0] len,
                          input int wk, input logic [3:0] wa, input logic [W-1:0] wd,
                          input int ck);
    logic [3:0] exp_s;
    exp_s = base;
    bus.Start = 1'b1;
    bus.Base  = base;
    bus.Len   = len;
    tick();
    bus.Start = 1'b0;
    for (int k = 0; k <= int'(len); k++) begin
      exp_s = 4'((int'(base) + k) % 16);
      check("scan.S", bus.S, exp_s);
      check("scan.E", bus.E, 1'b1);
      check("scan.Busy", bus.Busy, 1'b1);
      check("scan.Done", bus.Done, 1'b0);
      check("scan.Z", w_z, m_regs[exp_s]);
      if (k == wk) begin
        bus.WE = 1'b1;
        bus.WA = wa;
        bus.WD = wd;
      end
      if (k == ck) bus.Clr = 1'b1;
      tick();
      if (k == wk) begin
        m_regs[wa] = wd;
        bus.WE = 1'b0;
      end
      if (k == ck) begin
        for (int i = 0; i < 16; i++) m_regs[i] = '0;
        bus.Clr = 1'b0;
      end
    end
    check("done.Done", bus.Done, 1'b1);
    check("done.E", bus.E, 1'b0);
    check("done.Busy", bus.Busy, 1'b0);
    check("done.S", bus.S, exp_s);
    tick();
    check_idle("post");
    check("post.S", bus.S, exp_s);
    check("post.X", bus.X, model_flat());
  endtask

  initial begin
    checks    = 0;
    errors    = 0;
    rst_n     = 1'b1;
    bus.WE    = 1'b0;
    bus.WA    = 4'd0;
    bus.WD    = '0;
    bus.Clr   = 1'b0;
    bus.Start = 1'b0;
    bus.Base  = 4'd0;
    bus.Len   = 4'd0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;

    // Reset asserted between clock edges must act at once.
    #1 rst_n = 1'b0;
    #2;
    check("rst.X", bus.X, '0);
    check("rst.S", bus.S, 4'd0);
    check_idle("rst");
    repeat (2) @(posedge clk);
    #2 rst_n = 1'b1;
    tick();
    check_idle("rel");

    for (int i = 0; i < 16; i++) write_reg(4'(i), W'(1) << i);
    check("load.X0", bus.X[0 +: W], 16'd1);
    check("load.X8", bus.X[8*W +: W], 16'd256);
    check("load.X15", bus.X[15*W +: W], 16'd32768);

    run_scan(4'd0, 4'd15, -1, 4'd0, '0, -1);
    run_scan(4'd14, 4'd3, -1, 4'd0, '0, -1);

    // Start held high: restart only once IDLE has been re-entered.
    bus.Start = 1'b1;
    bus.Base  = 4'd7;
    bus.Len   = 4'd0;
    tick();
    check("one.S", bus.S, 4'd7);
    check("one.E", bus.E, 1'b1);
    tick();
    check("one.Done", bus.Done, 1'b1);
    check("one.E2", bus.E, 1'b0);
    tick();
    check_idle("one.idle");
    tick();
    check("one.reS", bus.S, 4'd7);
    check("one.reE", bus.E, 1'b1);
    check("one.reBusy", bus.Busy, 1'b1);
    bus.Start = 1'b0;
    tick();
    check("one.reDone", bus.Done, 1'b1);
    tick();
    check_idle("one.end");

    // Write to reg 5 lands exactly when S reaches 5.
    run_scan(4'd3, 4'd5, 1, 4'd5, 16'd1000, -1);
    check("wds.X5", bus.X[5*W +: W], 16'd1000);

    bus.WE  = 1'b1;
    bus.WA  = 4'd3;
    bus.WD  = 16'hFFFF;
    bus.Clr = 1'b1;
    tick();
    bus.WE  = 1'b0;
    bus.Clr = 1'b0;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    check("clr.X3", bus.X[3*W +: W], 16'd0);
    check("clr.X", bus.X, model_flat());

    for (int i = 0; i < 16; i++) write_reg(4'(i), W'($urandom));
    run_scan(4'd2, 4'd6, 2, 4'd9, 16'hABCD, 4);

    // Reset in the middle of a scan aborts it without a Done pulse.
    for (int i = 0; i < 16; i++) write_reg(4'(i), W'($urandom));
    bus.Start = 1'b1;
    bus.Base  = 4'd9;
    bus.Len   = 4'd5;
    tick();
    bus.Start = 1'b0;
    check("mid.S", bus.S, 4'd9);
    check("mid.Busy", bus.Busy, 1'b1);
    #2 rst_n = 1'b0;
    #1;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    check_idle("mid.rst");
    check("mid.rstS", bus.S, 4'd0);
    check("mid.rstX", bus.X, model_flat());
    #2 rst_n = 1'b1;
    for (int c = 0; c < 4; c++) begin
      tick();
      check_idle("mid.after");
    end
    run_scan(4'd9, 4'd5, -1, 4'd0, '0, -1);

    for (int r = 0; r < 16; r++) begin
      logic [3:0] rb;
      logic [3:0] rl;
      int         rwk;
      int         rck;
      for (int j = 0; j < 3; j++) write_reg(4'($urandom_range(0, 15)), W'($urandom));
      rb  = 4'($urandom_range(0, 15));
      rl  = 4'($urandom_range(0, 15));
      rwk = $urandom_range(0, int'(rl) + 1) - 1;
      rck = (r % 4 == 3) ? int'($urandom_range(0, int'(rl))) : -1;
      run_scan(rb, rl, rwk, 4'($urandom_range(0, 15)), W'($urandom), rck);
      if ($urandom_range(0, 1) == 1) tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
